// File: rtl/usb_spiflash_arbiter.sv
// Two-client arbiter in front of a single usb_spiflash_bridge: one owner per
// transaction, frozen address/security, grant held until the bridge is idle.
module usb_spiflash_arbiter #(
   parameter int ROUND_ROBIN  = 1,
   parameter int GUARD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] c0_address,
   input  logic        c0_security,
   input  logic        c0_rd_request,
   input  logic        c0_wr_request,
   input  logic        c0_rd_data_free,
   output logic        c0_rd_data_put,
   output logic [7:0]  c0_rd_data,
   input  logic        c0_wr_data_avail,
   output logic        c0_wr_data_get,
   input  logic [7:0]  c0_wr_data,
   output logic        c0_wr_busy,
   output logic        c0_grant,
   input  logic [15:0] c1_address,
   input  logic        c1_security,
   input  logic        c1_rd_request,
   input  logic        c1_wr_request,
   input  logic        c1_rd_data_free,
   output logic        c1_rd_data_put,
   output logic [7:0]  c1_rd_data,
   input  logic        c1_wr_data_avail,
   output logic        c1_wr_data_get,
   input  logic [7:0]  c1_wr_data,
   output logic        c1_wr_busy,
   output logic        c1_grant,
   output logic [15:0] fl_address,
   output logic        fl_security,
   output logic        fl_rd_request,
   output logic        fl_wr_request,
   output logic        fl_rd_data_free,
   output logic        fl_wr_data_avail,
   output logic [7:0]  fl_wr_data,
   input  logic        fl_rd_data_put,
   input  logic        fl_wr_busy,
   input  logic        fl_wr_data_get,
   input  logic [7:0]  fl_rd_data
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      WR       = 3'd2,
      WR_DRAIN = 3'd3,
      GUARD    = 3'd4
   } state_t;

   localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

   state_t      state_r, state_nx_s;
   logic        owner_r, last_owner_r;
   logic [15:0] guard_cnt_r, guard_nx_s;
   logic        load_s, winner_s;
   logic        req0_s, req1_s;
   logic        own_rd_req_s, own_wr_req_s, own_rd_free_s, own_wr_avail_s;
   logic [7:0]  own_wr_data_s;

   assign req0_s         = c0_rd_request | c0_wr_request;
   assign req1_s         = c1_rd_request | c1_wr_request;
   assign own_rd_req_s   = owner_r ? c1_rd_request    : c0_rd_request;
   assign own_wr_req_s   = owner_r ? c1_wr_request    : c0_wr_request;
   assign own_rd_free_s  = owner_r ? c1_rd_data_free  : c0_rd_data_free;
   assign own_wr_avail_s = owner_r ? c1_wr_data_avail : c0_wr_data_avail;
   assign own_wr_data_s  = owner_r ? c1_wr_data       : c0_wr_data;
   assign c0_rd_data     = fl_rd_data;
   assign c1_rd_data     = fl_rd_data;

   // State, ownership and frozen bridge address/security registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         owner_r      <= 1'b0;
         last_owner_r <= 1'b1;
         fl_address   <= 16'h0000;
         fl_security  <= 1'b0;
         guard_cnt_r  <= 16'd0;
      end else begin
         state_r     <= state_nx_s;
         guard_cnt_r <= guard_nx_s;
         if (load_s) begin
            owner_r      <= winner_s;
            last_owner_r <= winner_s;
            fl_address   <= winner_s ? c1_address : c0_address;
            fl_security  <= winner_s ? c1_security : c0_security;
         end
      end
   end

   // Next-state selection and owner-routed pass-through of requests and strobes
   always_comb begin
      state_nx_s       = state_r;
      guard_nx_s       = guard_cnt_r;
      load_s           = 1'b0;
      winner_s         = 1'b0;
      fl_rd_request    = 1'b0;
      fl_wr_request    = 1'b0;
      fl_rd_data_free  = 1'b0;
      fl_wr_data_avail = 1'b0;
      fl_wr_data       = 8'h00;
      c0_rd_data_put   = 1'b0;
      c1_rd_data_put   = 1'b0;
      c0_wr_data_get   = 1'b0;
      c1_wr_data_get   = 1'b0;
      c0_wr_busy       = 1'b0;
      c1_wr_busy       = 1'b0;
      c0_grant         = 1'b0;
      c1_grant         = 1'b0;
      case (state_r)
         IDLE: begin
            guard_nx_s = 16'd0;
            if (req0_s || req1_s) begin
               load_s = 1'b1;
               if (req0_s && req1_s) begin
                  winner_s = (ROUND_ROBIN != 0) ? ~last_owner_r : 1'b0;
               end else if (req1_s) begin
                  winner_s = 1'b1;
               end else begin
                  winner_s = 1'b0;
               end
               // Read wins over write when one client raises both
               if (winner_s ? c1_rd_request : c0_rd_request) begin
                  state_nx_s = RD;
               end else begin
                  state_nx_s = WR;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         RD: begin
            fl_rd_request   = own_rd_req_s;
            fl_rd_data_free = own_rd_free_s;
            c0_rd_data_put  = ~owner_r & fl_rd_data_put;
            c1_rd_data_put  = owner_r & fl_rd_data_put;
            c0_wr_busy      = owner_r;
            c1_wr_busy      = ~owner_r;
            c0_grant        = ~owner_r;
            c1_grant        = owner_r;
            if (!own_rd_req_s) begin
               state_nx_s = GUARD;
            end else begin
               state_nx_s = RD;
            end
         end
         WR: begin
            fl_wr_request    = own_wr_req_s;
            fl_wr_data_avail = own_wr_avail_s;
            fl_wr_data       = own_wr_data_s;
            c0_wr_data_get   = ~owner_r & fl_wr_data_get;
            c1_wr_data_get   = owner_r & fl_wr_data_get;
            c0_wr_busy       = owner_r ? 1'b1 : fl_wr_busy;
            c1_wr_busy       = owner_r ? fl_wr_busy : 1'b1;
            c0_grant         = ~owner_r;
            c1_grant         = owner_r;
            if (!own_wr_req_s) begin
               state_nx_s = WR_DRAIN;
            end else begin
               state_nx_s = WR;
            end
         end
         WR_DRAIN: begin
            c0_wr_busy = owner_r ? 1'b1 : fl_wr_busy;
            c1_wr_busy = owner_r ? fl_wr_busy : 1'b1;
            c0_grant   = ~owner_r;
            c1_grant   = owner_r;
            if (!fl_wr_busy) begin
               state_nx_s = GUARD;
            end else begin
               state_nx_s = WR_DRAIN;
            end
         end
         GUARD: begin
            c0_wr_busy = 1'b1;
            c1_wr_busy = 1'b1;
            if (guard_cnt_r == GUARD_LAST) begin
               guard_nx_s = 16'd0;
               state_nx_s = IDLE;
            end else begin
               guard_nx_s = guard_cnt_r + 16'd1;
               state_nx_s = GUARD;
            end
         end
         default: begin
            state_nx_s = IDLE;
            guard_nx_s = 16'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_usb_spiflash_arbiter.sv
// Directed bench for usb_spiflash_arbiter: a round-robin instance plus a
// fixed-priority instance sharing the client-side stimulus.
module tb_usb_spiflash_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] c0_address, c1_address;
   logic        c0_security, c1_security;
   logic        c0_rd_request, c1_rd_request, c0_wr_request, c1_wr_request;
   logic        c0_rd_data_free, c1_rd_data_free;
   logic        c0_wr_data_avail, c1_wr_data_avail;
   logic [7:0]  c0_wr_data, c1_wr_data;
   logic        fl_rd_data_put, fl_wr_busy, fl_wr_data_get;
   logic [7:0]  fl_rd_data;

   logic        c0_rd_data_put, c1_rd_data_put, c0_wr_data_get, c1_wr_data_get;
   logic [7:0]  c0_rd_data, c1_rd_data;
   logic        c0_wr_busy, c1_wr_busy, c0_grant, c1_grant;
   logic [15:0] fl_address;
   logic        fl_security, fl_rd_request, fl_wr_request, fl_rd_data_free, fl_wr_data_avail;
   logic [7:0]  fl_wr_data;

   logic        fp_c0_rd_data_put, fp_c1_rd_data_put, fp_c0_wr_data_get, fp_c1_wr_data_get;
   logic [7:0]  fp_c0_rd_data, fp_c1_rd_data;
   logic        fp_c0_wr_busy, fp_c1_wr_busy, fp_c0_grant, fp_c1_grant;
   logic [15:0] fp_fl_address;
   logic        fp_fl_security, fp_fl_rd_request, fp_fl_wr_request, fp_fl_rd_data_free;
   logic        fp_fl_wr_data_avail;
   logic [7:0]  fp_fl_wr_data;
   logic        fp_zero = 1'b0;
   logic [7:0]  fp_zero8 = 8'h00;

   int n_checks = 0;
   int n_fail   = 0;
   int bad;

   always #5 clk = ~clk;

   usb_spiflash_arbiter #(.ROUND_ROBIN(1), .GUARD_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .c0_address(c0_address), .c0_security(c0_security),
      .c0_rd_request(c0_rd_request), .c0_wr_request(c0_wr_request),
      .c0_rd_data_free(c0_rd_data_free), .c0_rd_data_put(c0_rd_data_put),
      .c0_rd_data(c0_rd_data), .c0_wr_data_avail(c0_wr_data_avail),
      .c0_wr_data_get(c0_wr_data_get), .c0_wr_data(c0_wr_data),
      .c0_wr_busy(c0_wr_busy), .c0_grant(c0_grant),
      .c1_address(c1_address), .c1_security(c1_security),
      .c1_rd_request(c1_rd_request), .c1_wr_request(c1_wr_request),
      .c1_rd_data_free(c1_rd_data_free), .c1_rd_data_put(c1_rd_data_put),
      .c1_rd_data(c1_rd_data), .c1_wr_data_avail(c1_wr_data_avail),
      .c1_wr_data_get(c1_wr_data_get), .c1_wr_data(c1_wr_data),
      .c1_wr_busy(c1_wr_busy), .c1_grant(c1_grant),
      .fl_address(fl_address), .fl_security(fl_security),
      .fl_rd_request(fl_rd_request), .fl_wr_request(fl_wr_request),
      .fl_rd_data_free(fl_rd_data_free), .fl_wr_data_avail(fl_wr_data_avail),
      .fl_wr_data(fl_wr_data), .fl_rd_data_put(fl_rd_data_put),
      .fl_wr_busy(fl_wr_busy), .fl_wr_data_get(fl_wr_data_get),
      .fl_rd_data(fl_rd_data)
   );

   usb_spiflash_arbiter #(.ROUND_ROBIN(0), .GUARD_CYCLES(4)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .c0_address(c0_address), .c0_security(c0_security),
      .c0_rd_request(c0_rd_request), .c0_wr_request(c0_wr_request),
      .c0_rd_data_free(c0_rd_data_free), .c0_rd_data_put(fp_c0_rd_data_put),
      .c0_rd_data(fp_c0_rd_data), .c0_wr_data_avail(c0_wr_data_avail),
      .c0_wr_data_get(fp_c0_wr_data_get), .c0_wr_data(c0_wr_data),
      .c0_wr_busy(fp_c0_wr_busy), .c0_grant(fp_c0_grant),
      .c1_address(c1_address), .c1_security(c1_security),
      .c1_rd_request(c1_rd_request), .c1_wr_request(c1_wr_request),
      .c1_rd_data_free(c1_rd_data_free), .c1_rd_data_put(fp_c1_rd_data_put),
      .c1_rd_data(fp_c1_rd_data), .c1_wr_data_avail(c1_wr_data_avail),
      .c1_wr_data_get(fp_c1_wr_data_get), .c1_wr_data(c1_wr_data),
      .c1_wr_busy(fp_c1_wr_busy), .c1_grant(fp_c1_grant),
      .fl_address(fp_fl_address), .fl_security(fp_fl_security),
      .fl_rd_request(fp_fl_rd_request), .fl_wr_request(fp_fl_wr_request),
      .fl_rd_data_free(fp_fl_rd_data_free), .fl_wr_data_avail(fp_fl_wr_data_avail),
      .fl_wr_data(fp_fl_wr_data), .fl_rd_data_put(fp_zero),
      .fl_wr_busy(fp_zero), .fl_wr_data_get(fp_zero),
      .fl_rd_data(fp_zero8)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      c0_address = 16'h0000; c1_address = 16'h0000;
      c0_security = 1'b0;    c1_security = 1'b0;
      c0_rd_request = 1'b0;  c1_rd_request = 1'b0;
      c0_wr_request = 1'b0;  c1_wr_request = 1'b0;
      c0_rd_data_free = 1'b0; c1_rd_data_free = 1'b0;
      c0_wr_data_avail = 1'b0; c1_wr_data_avail = 1'b0;
      c0_wr_data = 8'h00;    c1_wr_data = 8'h00;
      fl_rd_data_put = 1'b0; fl_wr_busy = 1'b0; fl_wr_data_get = 1'b0;
      fl_rd_data = 8'hA5;
      step(2);

      // reset state
      check_eq("rst_c0_grant", {31'd0, c0_grant}, 32'd0);
      check_eq("rst_c1_grant", {31'd0, c1_grant}, 32'd0);
      check_eq("rst_fl_address", {16'd0, fl_address}, 32'h0000);
      check_eq("rst_fl_rd_request", {31'd0, fl_rd_request}, 32'd0);
      check_eq("rst_c0_wr_busy", {31'd0, c0_wr_busy}, 32'd0);
      check_eq("rst_c0_rd_data", {24'd0, c0_rd_data}, 32'hA5);
      reset_n = 1'b1;

      // single read by c0
      c0_address = 16'h0012; c0_security = 1'b1;
      c0_rd_request = 1'b1; c0_rd_data_free = 1'b1;
      step(1);
      check_eq("rd_c0_grant", {31'd0, c0_grant}, 32'd1);
      check_eq("rd_c1_grant", {31'd0, c1_grant}, 32'd0);
      check_eq("rd_fl_address", {16'd0, fl_address}, 32'h0012);
      check_eq("rd_fl_security", {31'd0, fl_security}, 32'd1);
      check_eq("rd_fl_rd_request", {31'd0, fl_rd_request}, 32'd1);
      check_eq("rd_c1_wr_busy", {31'd0, c1_wr_busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         fl_rd_data_put = 1'b1;
         fl_rd_data = 8'hB0 + 8'(i);
         #1;
         check_eq("rd_c0_put", {31'd0, c0_rd_data_put}, 32'd1);
         check_eq("rd_c1_put", {31'd0, c1_rd_data_put}, 32'd0);
         check_eq("rd_c0_data", {24'd0, c0_rd_data}, 32'hB0 + 32'(i));
         step(1);
      end
      fl_rd_data_put = 1'b0;
      c0_rd_request = 1'b0;
      #1;
      check_eq("rd_drop_same_cycle", {31'd0, fl_rd_request}, 32'd0);
      step(1);
      check_eq("guard_c0_grant", {31'd0, c0_grant}, 32'd0);
      c1_address = 16'h0034; c1_rd_request = 1'b1; c1_rd_data_free = 1'b1;
      step(4);
      check_eq("guard_wait_c1_grant", {31'd0, c1_grant}, 32'd0);
      step(1);
      check_eq("guard_then_c1_grant", {31'd0, c1_grant}, 32'd1);
      check_eq("c1_rd_fl_address", {16'd0, fl_address}, 32'h0034);
      fl_rd_data_put = 1'b1;
      #1;
      check_eq("c1_rd_put", {31'd0, c1_rd_data_put}, 32'd1);
      check_eq("c1_rd_c0_put", {31'd0, c0_rd_data_put}, 32'd0);
      fl_rd_data_put = 1'b0;
      c1_rd_request = 1'b0;
      step(5);

      // contention after reset: c0 then c1, long busy, address freeze
      reset_n = 1'b0;
      c0_address = 16'h0300; c1_address = 16'h0100;
      c0_wr_request = 1'b1; c1_wr_request = 1'b1;
      c0_wr_data_avail = 1'b1; c0_wr_data = 8'h5A;
      step(1);
      reset_n = 1'b1;
      step(1);
      check_eq("cont_c0_grant", {31'd0, c0_grant}, 32'd1);
      check_eq("cont_c1_grant", {31'd0, c1_grant}, 32'd0);
      check_eq("cont_fl_address", {16'd0, fl_address}, 32'h0300);
      check_eq("cont_fl_wr_request", {31'd0, fl_wr_request}, 32'd1);
      check_eq("cont_c0_wr_busy_first", {31'd0, c0_wr_busy}, 32'd0);
      fl_wr_data_get = 1'b1;
      #1;
      check_eq("wr_c0_get", {31'd0, c0_wr_data_get}, 32'd1);
      check_eq("wr_c1_get", {31'd0, c1_wr_data_get}, 32'd0);
      check_eq("wr_fl_data", {24'd0, fl_wr_data}, 32'h5A);
      check_eq("wr_fl_avail", {31'd0, fl_wr_data_avail}, 32'd1);
      fl_wr_data_get = 1'b0;
      for (int i = 0; i < 6; i++) begin
         fl_wr_busy = i[0];
         #1;
         check_eq("wr_c0_busy_track", {31'd0, c0_wr_busy}, {31'd0, i[0]});
         check_eq("wr_c1_busy", {31'd0, c1_wr_busy}, 32'd1);
         step(1);
      end
      fl_wr_busy = 1'b1;
      c0_wr_request = 1'b0;
      c0_wr_data_avail = 1'b0;
      #1;
      check_eq("wr_drop_fl_req", {31'd0, fl_wr_request}, 32'd0);
      step(1);
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         if (c1_wr_busy !== 1'b1 || c0_wr_busy !== 1'b1 || c1_grant !== 1'b0 ||
             c0_grant !== 1'b1 || fl_wr_request !== 1'b0) begin
            bad++;
         end
         step(1);
      end
      check_eq("drain_hold_errors", 32'(bad), 32'd0);
      fl_wr_busy = 1'b0;
      step(4);
      check_eq("drain_guard_c1_grant", {31'd0, c1_grant}, 32'd0);
      step(1);
      check_eq("idle_c1_grant", {31'd0, c1_grant}, 32'd0);
      check_eq("idle_c0_wr_busy", {31'd0, c0_wr_busy}, 32'd0);
      check_eq("idle_c1_wr_busy", {31'd0, c1_wr_busy}, 32'd0);
      step(1);
      check_eq("c1_wr_grant", {31'd0, c1_grant}, 32'd1);
      check_eq("c1_wr_fl_address", {16'd0, fl_address}, 32'h0100);
      c1_address = 16'h0200;
      step(1);
      check_eq("freeze_wr", {16'd0, fl_address}, 32'h0100);
      fl_wr_busy = 1'b1;
      c1_wr_request = 1'b0;
      step(1);
      check_eq("freeze_drain", {16'd0, fl_address}, 32'h0100);
      check_eq("c1_drain_grant", {31'd0, c1_grant}, 32'd1);
      check_eq("c1_drain_c0_busy", {31'd0, c0_wr_busy}, 32'd1);
      step(2);
      check_eq("freeze_drain_late", {16'd0, fl_address}, 32'h0100);
      fl_wr_busy = 1'b0;
      step(5);

      // alternation on the round-robin instance, c0 always on fixed priority
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      c0_address = 16'h0A00; c1_address = 16'h0B00;
      for (int r = 0; r < 4; r++) begin
         c0_rd_request = 1'b1; c1_rd_request = 1'b1;
         step(1);
         check_eq("rr_c0_grant", {31'd0, c0_grant}, {31'd0, ~r[0]});
         check_eq("rr_c1_grant", {31'd0, c1_grant}, {31'd0, r[0]});
         check_eq("rr_fl_address", {16'd0, fl_address}, r[0] ? 32'h0B00 : 32'h0A00);
         check_eq("fp_c0_grant", {31'd0, fp_c0_grant}, 32'd1);
         check_eq("fp_c1_grant", {31'd0, fp_c1_grant}, 32'd0);
         c0_rd_request = 1'b0; c1_rd_request = 1'b0;
         step(5);
      end

      // reset in the middle of a read
      c0_address = 16'h0042; c0_rd_request = 1'b1;
      step(1);
      check_eq("mid_c0_grant", {31'd0, c0_grant}, 32'd1);
      check_eq("mid_fl_rd_request", {31'd0, fl_rd_request}, 32'd1);
      reset_n = 1'b0;
      step(1);
      check_eq("mid_rst_fl_rd_request", {31'd0, fl_rd_request}, 32'd0);
      check_eq("mid_rst_c0_grant", {31'd0, c0_grant}, 32'd0);
      check_eq("mid_rst_fl_address", {16'd0, fl_address}, 32'h0000);
      reset_n = 1'b1;
      c0_rd_request = 1'b0;
      c1_address = 16'h0777; c1_rd_request = 1'b1;
      step(1);
      check_eq("post_rst_c1_grant", {31'd0, c1_grant}, 32'd1);
      check_eq("post_rst_fl_address", {16'd0, fl_address}, 32'h0777);
      check_eq("post_rst_fl_rd_request", {31'd0, fl_rd_request}, 32'd1);
      c1_rd_request = 1'b0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_spiflash_arbiter.md
# usb_spiflash_arbiter

Two-client arbiter sharing one `usb_spiflash_bridge` instance, e.g. the DFU control-endpoint engine (client 0) and the bitstream/config loader (client 1). Grants the bridge to one client per transaction, freezes that client's page address and security flag for the whole transaction, and holds the grant until the bridge is truly idle (program/erase finished, CSEL released). Sits between the clients and the bridge; the bridge itself is unmodified.

## Interface
- `ROUND_ROBIN`, 1: 1 = alternate on contention; 0 = client 0 always wins.
- `GUARD_CYCLES`, 4: idle cycles enforced after each transaction before the next grant (≥1).

- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `cN_address`  in  16  client N page address (N = 0, 1; applies to all `cN_` ports).
- `cN_security`  in  1  client N security-register access.
- `cN_rd_request` / `cN_wr_request`  in  1  client N read / write request.
- `cN_rd_data_free`  in  1  client N can accept a read byte.
- `cN_rd_data_put`  out  1  read byte strobe to client N.
- `cN_rd_data`  out  8  read data; `fl_rd_data` broadcast to both clients.
- `cN_wr_data_avail`  in  1  client N has write data.
- `cN_wr_data_get`  out  1  write byte consumed from client N.
- `cN_wr_data`  in  8  client N write data.
- `cN_wr_busy`  out  1  flash unavailable/busy, as seen by client N.
- `cN_grant`  out  1  client N owns the bridge.
- `fl_address`  out  16, `fl_security`  out  1: registered bridge address/security.
- `fl_rd_request`, `fl_wr_request`, `fl_rd_data_free`, `fl_wr_data_avail`  out  1; `fl_wr_data`  out  8.
- `fl_rd_data_put`, `fl_wr_busy`, `fl_wr_data_get`  in  1; `fl_rd_data`  in  8.

## Operation
- States: IDLE, RD, WR, WR_DRAIN, GUARD. Registers: `owner`, `last_owner`, `fl_address`, `fl_security`, guard counter.
- IDLE: client N requests when `cN_rd_request | cN_wr_request`. If both request, pick per `ROUND_ROBIN` (the client ≠ `last_owner`) or client 0. On the leaving edge, latch the winner's address/security into `fl_address`/`fl_security`, set `owner`/`last_owner`. Go to RD if the winner's `rd_request` is high (read beats write within one client), else WR.
- RD: `fl_rd_request = c[owner]_rd_request`, `fl_rd_data_free = c[owner]_rd_data_free`, `c[owner]_rd_data_put = fl_rd_data_put`. The owner's `wr_request` is ignored. When the owner's `rd_request` drops, `fl_rd_request` drops the same cycle; go to GUARD.
- WR: `fl_wr_request = c[owner]_wr_request`, `fl_wr_data_avail`/`fl_wr_data` from the owner, `c[owner]_wr_data_get = fl_wr_data_get`. When the owner's `wr_request` drops, go to WR_DRAIN.
- WR_DRAIN: wait for `fl_wr_busy == 0`, then go to GUARD.
- GUARD: count `GUARD_CYCLES`; all `fl_*` requests low; then go to IDLE.
- Non-owner (and everyone in IDLE/GUARD): `rd_data_put = 0`, `wr_data_get = 0`, `grant = 0`.
- `cN_wr_busy`:
  - Owner in WR/WR_DRAIN: `fl_wr_busy`.
  - Non-owner while state ≠ IDLE: 1.
  - Otherwise: 0.
- Address/security changes from a client after grant are ignored until the next grant.

## Timing
- Reset (`reset_n` low at a clock edge): state IDLE, `last_owner` = 1 (client 0 wins the first contention), `fl_address` = 0, `fl_security` = 0. All `fl_` and `cN_` outputs 0 except `cN_rd_data` (follows `fl_rd_data`).
- Reset mid-transaction: requests drop the next cycle. The bridge is reset by the same system reset.
- Grant latency: request sampled high in IDLE at edge k → `cN_grant`, `fl_address` and `fl_*_request` valid in cycle k+1.
- Request pass-through in RD/WR is combinational (0 cycles); data strobes are combinational pass-through.
- Release: read → `GUARD_CYCLES` cycles in GUARD. Write → WR_DRAIN while `fl_wr_busy` is high, then `GUARD_CYCLES`. The next grant is visible 1 cycle after GUARD ends.
- `fl_wr_busy` is low in the first WR cycle (the bridge asserts it one cycle later). WR_DRAIN is only entered from WR, after the bridge has sampled `fl_wr_request`, so the drain cannot exit early.
- A new request arriving during GUARD waits; it is not lost.

## Test plan
- Single read: c0 reads page 0x0012, holds for 4 bytes with `rd_data_free` = 1 → `c0_grant` at k+1, `fl_address` = 0x0012, 4 `c0_rd_data_put` pulses, `c1_rd_data_put` stays 0, 4 GUARD cycles, then IDLE.
- Contention after reset: c0 and c1 both raise `wr_request` at the same edge, `ROUND_ROBIN` = 1 → c0 granted first. c1 granted only after `fl_wr_busy` falls + 4 cycles. Next simultaneous contention → c1 wins.
- Fixed priority: `ROUND_ROBIN` = 0, repeated simultaneous requests → c0 always wins.
- Address freeze: c1 write at 0x0100, changes `c1_address` to 0x0200 mid-write → `fl_address` stays 0x0100 through WR_DRAIN.
- Busy visibility: c0 writes with `fl_wr_busy` held high 500 cycles → `c1_wr_busy` = 1 throughout and `c0_wr_busy` tracks `fl_wr_busy`. Both `cN_wr_busy` = 0 after return to IDLE.
- Reset mid-read: `reset_n` low during RD → next cycle `fl_rd_request` = 0, `c0_grant` = 0, state IDLE. A fresh c1 request after reset is granted at k+1.
